// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response channel between one requester and the ALU arbiter
interface alu_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic              valid;
  logic              ready;
  logic [WIDTH-1:0]  srca;
  logic [WIDTH-1:0]  srcb;
  logic [CTRL_W-1:0] ctrl;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  result;
  logic              zero;

  modport master (
    output valid, srca, srcb, ctrl, rsp_ready,
    input  ready, rsp_valid, result, zero
  );

  modport slave (
    input  valid, srca, srcb, ctrl, rsp_ready,
    output ready, rsp_valid, result, zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external single-cycle ALU between two requesters
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int CTRL_W    = 4,
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  alu_arbiter_if.slave      r0,
  alu_arbiter_if.slave      r1,
  output logic [WIDTH-1:0]  alu_srca,
  output logic [WIDTH-1:0]  alu_srcb,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [CTRL_W-1:0] op_ctrl;
  logic              owner;
  logic              last_grant;
  logic [WIDTH-1:0]  res;
  logic              res_zero;

  logic grant;
  logic any_valid;
  logic owner_rsp_ready;
  logic accept_win;
  logic accept;

  // A new request may enter while the owner is collecting its result, giving back-to-back ops.
  always_comb begin
    any_valid = r0.valid | r1.valid;
    if (r0.valid && r1.valid) begin
      grant = RR_ENABLE ? ~last_grant : 1'b0;
    end else begin
      grant = r1.valid;
    end
    owner_rsp_ready = owner ? r1.rsp_ready : r0.rsp_ready;
    accept_win      = (state == IDLE) || ((state == RESP) && owner_rsp_ready);
    accept          = accept_win & any_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? EXEC : IDLE;
      EXEC:    state_nxt = RESP;
      RESP: begin
        if (owner_rsp_ready) begin
          state_nxt = accept ? EXEC : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    r0.ready     = accept & ~grant;
    r1.ready     = accept & grant;
    r0.rsp_valid = (state == RESP) & ~owner;
    r1.rsp_valid = (state == RESP) & owner;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      res        <= '0;
      res_zero   <= 1'b0;
    end else begin
      if (accept) begin
        op_a       <= grant ? r1.srca : r0.srca;
        op_b       <= grant ? r1.srcb : r0.srcb;
        op_ctrl    <= grant ? r1.ctrl : r0.ctrl;
        owner      <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        res      <= alu_result;
        res_zero <= alu_zero;
      end
    end
  end

  assign alu_srca  = op_a;
  assign alu_srcb  = op_b;
  assign alu_ctrl  = op_ctrl;
  assign r0.result = res;
  assign r0.zero   = res_zero;
  assign r1.result = res;
  assign r1.zero   = res_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a transaction-level reference model
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  alu_arbiter_if #(.WIDTH(32), .CTRL_W(4)) r0 ();
  alu_arbiter_if #(.WIDTH(32), .CTRL_W(4)) r1 ();
  alu_arbiter_if #(.WIDTH(32), .CTRL_W(4)) f0 ();
  alu_arbiter_if #(.WIDTH(32), .CTRL_W(4)) f1 ();

  logic [31:0] alu_srca, alu_srcb, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic [31:0] alu2_srca, alu2_srcb, alu2_result;
  logic [3:0]  alu2_ctrl;
  logic        alu2_zero;

  // Reference ALU: result plus zero flag in bit 32; unknown codes give 0 / zero=1.
  function automatic logic [32:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (c)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << b[4:0];
      4'd6:    r = a >> b[4:0];
      4'd7:    r = {31'd0, $signed(a) < $signed(b)};
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero, alu_result}   = alu_ref(alu_ctrl, alu_srca, alu_srcb);
  assign {alu2_zero, alu2_result} = alu_ref(alu2_ctrl, alu2_srca, alu2_srcb);

  alu_arbiter #(.WIDTH(32), .CTRL_W(4), .RR_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .r0(r0), .r1(r1),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu_arbiter #(.WIDTH(32), .CTRL_W(4), .RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .r0(f0), .r1(f1),
    .alu_srca(alu2_srca), .alu_srcb(alu2_srcb), .alu_ctrl(alu2_ctrl),
    .alu_result(alu2_result), .alu_zero(alu2_zero)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Model: at most one operation in flight; its response is due two cycles after acceptance.
  bit          m_ok   = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_owner;
  bit          m_last = 1'b1;
  int          m_age;
  logic [31:0] m_res;
  logic        m_zero;

  always @(negedge clk) begin
    bit erv0, erv1, rel, free, g, er0, er1;
    logic [32:0] z;
    erv0 = m_pend && (m_age >= 1) && !m_owner;
    erv1 = m_pend && (m_age >= 1) && m_owner;
    rel  = (erv0 && r0.rsp_ready) || (erv1 && r1.rsp_ready);
    free = !m_pend || rel;
    if (r0.valid && r1.valid) g = !m_last;
    else                      g = r1.valid;
    er0 = free && r0.valid && !g;
    er1 = free && r1.valid && g;
    if (m_ok) begin
      chk("m_r0_ready", r0.ready, er0);
      chk("m_r1_ready", r1.ready, er1);
      chk("m_r0_rsp_valid", r0.rsp_valid, erv0);
      chk("m_r1_rsp_valid", r1.rsp_valid, erv1);
      if (erv0) begin
        chk("m_r0_result", r0.result, m_res);
        chk("m_r0_zero", r0.zero, m_zero);
      end
      if (erv1) begin
        chk("m_r1_result", r1.result, m_res);
        chk("m_r1_zero", r1.zero, m_zero);
      end
    end
    if (reset) begin
      m_ok   = 1'b1;
      m_pend = 1'b0;
      m_last = 1'b1;
    end else if (m_ok) begin
      if (m_pend) m_age++;
      if (rel) m_pend = 1'b0;
      if (er0 || er1) begin
        z = g ? alu_ref(r1.ctrl, r1.srca, r1.srcb) : alu_ref(r0.ctrl, r0.srca, r0.srcb);
        m_pend  = 1'b1;
        m_owner = g;
        m_age   = 0;
        m_res   = z[31:0];
        m_zero  = z[32];
        m_last  = g;
      end
    end
  end

  int fp_r0 = 0, fp_r1 = 0, fp_rsp1 = 0;
  always @(negedge clk) begin
    if (m_ok && !reset) begin
      if (f0.ready)     fp_r0++;
      if (f1.ready)     fp_r1++;
      if (f1.rsp_valid) fp_rsp1++;
      if (f0.rsp_valid) chk("fp_r0_result", f0.result, 64'd42);
    end
  end

  task automatic rand_op(output logic [31:0] a, output logic [31:0] b, output logic [3:0] c);
    c = 4'($urandom_range(0, 15));
    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
  endtask

  initial begin
    int g_log[6];
    int n;
    bit h0, h1;
    int pv, pr;

    reset = 1'b1;
    r0.valid = 1'b0; r0.srca = '0; r0.srcb = '0; r0.ctrl = '0; r0.rsp_ready = 1'b1;
    r1.valid = 1'b0; r1.srca = '0; r1.srcb = '0; r1.ctrl = '0; r1.rsp_ready = 1'b1;
    f0.valid = 1'b1; f0.srca = 32'd20; f0.srcb = 32'd22; f0.ctrl = 4'd0; f0.rsp_ready = 1'b1;
    f1.valid = 1'b1; f1.srca = 32'd20; f1.srcb = 32'd22; f1.ctrl = 4'd1; f1.rsp_ready = 1'b1;
    step(); step();
    reset = 1'b0;

    neg();
    chk("rst_r0_rsp_valid", r0.rsp_valid, 0);
    chk("rst_r1_rsp_valid", r1.rsp_valid, 0);
    chk("rst_alu_srca", alu_srca, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_result", r0.result, 0);
    chk("rst_zero", r0.zero, 0);

    // ADD 5,7 from r0 alone
    step(); r0.valid = 1'b1; r0.srca = 32'd5; r0.srcb = 32'd7; r0.ctrl = 4'd0;
    neg();  chk("add_r0_ready", r0.ready, 1); chk("add_r1_ready", r1.ready, 0);
    step(); r0.valid = 1'b0;
    neg();  chk("add_exec_rsp_valid", r0.rsp_valid, 0); chk("add_alu_srca", alu_srca, 5);
    step();
    neg();  chk("add_rsp_valid", r0.rsp_valid, 1); chk("add_result", r0.result, 12); chk("add_zero", r0.zero, 0);
    step();
    neg();  chk("add_released", r0.rsp_valid, 0);

    // SUB 9,9 from r1
    step(); r1.valid = 1'b1; r1.srca = 32'd9; r1.srcb = 32'd9; r1.ctrl = 4'd1;
    neg();  chk("sub_r1_ready", r1.ready, 1); chk("sub_r0_rsp_valid_a", r0.rsp_valid, 0);
    step(); r1.valid = 1'b0;
    neg();  chk("sub_r0_rsp_valid_b", r0.rsp_valid, 0);
    step();
    neg();  chk("sub_rsp_valid", r1.rsp_valid, 1); chk("sub_result", r1.result, 0);
            chk("sub_zero", r1.zero, 1); chk("sub_r0_rsp_valid_c", r0.rsp_valid, 0);
    step();

    // both requesting continuously: grants alternate starting with r0
    r0.valid = 1'b1; r1.valid = 1'b1;
    rand_op(r0.srca, r0.srcb, r0.ctrl);
    rand_op(r1.srca, r1.srcb, r1.ctrl);
    n = 0;
    for (int c = 0; c < 30 && n < 6; c++) begin
      neg();
      h0 = r0.ready; h1 = r1.ready;
      if (h0) begin g_log[n] = 0; n++; end
      else if (h1) begin g_log[n] = 1; n++; end
      step();
      if (h0) rand_op(r0.srca, r0.srcb, r0.ctrl);
      if (h1) rand_op(r1.srca, r1.srcb, r1.ctrl);
    end
    chk("rr_grant_count", n, 6);
    for (int i = 0; i < n; i++) chk("rr_grant_order", g_log[i], i % 2);
    r0.valid = 1'b0; r1.valid = 1'b0;
    repeat (4) step();

    // r0 OR 3,4 stalls its response five cycles while r1 waits with XOR
    r0.valid = 1'b1; r0.srca = 32'd3; r0.srcb = 32'd4; r0.ctrl = 4'd3; r0.rsp_ready = 1'b0;
    neg();  chk("stall_r0_ready", r0.ready, 1);
    step(); r0.valid = 1'b0;
    r1.valid = 1'b1; r1.srca = 32'h0000_ff00; r1.srcb = 32'h0000_0ff0; r1.ctrl = 4'd4;
    neg();  chk("stall_exec_r1_ready", r1.ready, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      neg();
      chk("stall_rsp_valid", r0.rsp_valid, 1);
      chk("stall_result", r0.result, 7);
      chk("stall_r1_ready", r1.ready, 0);
    end
    step(); r0.rsp_ready = 1'b1;
    neg();  chk("b2b_r1_ready", r1.ready, 1); chk("b2b_r0_rsp_valid", r0.rsp_valid, 1);
    step(); r1.valid = 1'b0;
    neg();  chk("xor_exec_rsp_valid", r1.rsp_valid, 0); chk("xor_exec_r0_rsp", r0.rsp_valid, 0);
    step();
    neg();  chk("xor_rsp_valid", r1.rsp_valid, 1); chk("xor_result", r1.result, 32'h0000_f0f0);
            chk("xor_zero", r1.zero, 0);
    step();

    // reset lands while SLL 1,4 is executing
    r0.valid = 1'b1; r0.srca = 32'd1; r0.srcb = 32'd4; r0.ctrl = 4'd5;
    neg();  chk("sll_r0_ready", r0.ready, 1);
    step(); r0.valid = 1'b0; reset = 1'b1;
    neg();
    step(); reset = 1'b0;
    neg();  chk("rstmid_rsp_valid", r0.rsp_valid, 0); chk("rstmid_result", r0.result, 0);
            chk("rstmid_alu_srca", alu_srca, 0);
    step();
    neg();  chk("rstmid_rsp_valid_b", r0.rsp_valid, 0);
    step(); r0.valid = 1'b1; r0.srca = 32'd10; r0.srcb = 32'd3; r0.ctrl = 4'd1;
    neg();  chk("post_rst_ready", r0.ready, 1);
    step(); r0.valid = 1'b0;
    neg();
    step();
    neg();  chk("post_rst_rsp_valid", r0.rsp_valid, 1); chk("post_rst_result", r0.result, 7);
    step();

    // randomized traffic with occasional resets, checked by the model
    for (int c = 0; c < 3000; c++) begin
      pv = (c < 1000) ? 100 : (c < 2000) ? 60 : 30;
      pr = (c < 1000) ? 100 : (c < 2000) ? 50 : 80;
      neg();
      h0 = r0.valid && r0.ready;
      h1 = r1.valid && r1.ready;
      step();
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1; r0.valid = 1'b0; r1.valid = 1'b0;
      end
      if (!reset) begin
        if (!r0.valid || h0) begin
          r0.valid = ($urandom_range(0, 99) < pv);
          rand_op(r0.srca, r0.srcb, r0.ctrl);
        end
        if (!r1.valid || h1) begin
          r1.valid = ($urandom_range(0, 99) < pv);
          rand_op(r1.srca, r1.srcb, r1.ctrl);
        end
      end
      r0.rsp_ready = ($urandom_range(0, 99) < pr);
      r1.rsp_ready = ($urandom_range(0, 99) < pr);
    end

    chk("fp_r1_never_ready", fp_r1, 0);
    chk("fp_r1_never_rsp", fp_rsp1, 0);
    chk("fp_r0_served", (fp_r0 > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
